// File: rtl/pattern_bank_if.sv
// Serial configuration link, playback control/stream and flattened storage
// view of a pattern_bank, bundled as one port.
interface pattern_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 27,
    parameter int NBUFS = 8,
    parameter int SELW  = 3
);
    logic                         ssel;
    logic                         sin;
    logic [SELW-1:0]              saddr;
    logic                         sout;
    logic                         ovf;
    logic                         ovf_clr;
    logic                         play_go;
    logic                         play_stop;
    logic [SELW-1:0]              play_sel;
    logic                         play_loop;
    logic [WIDTH-1:0]             pat_byte;
    logic                         pat_valid;
    logic                         pat_last;
    logic                         busy;
    logic [NBUFS*DEPTH*WIDTH-1:0] bufs;

    modport master (
        output ssel, sin, saddr, ovf_clr, play_go, play_stop, play_sel, play_loop,
        input  sout, ovf, pat_byte, pat_valid, pat_last, busy, bufs
    );

    modport slave (
        input  ssel, sin, saddr, ovf_clr, play_go, play_stop, play_sel, play_loop,
        output sout, ovf, pat_byte, pat_valid, pat_last, busy, bufs
    );
endinterface

// File: rtl/pattern_bank.sv
// Bank of NBUFS pattern buffers loaded bit-serially with simultaneous readback,
// plus a playback sequencer streaming one buffer word-by-word, once or looped.
module pattern_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 27,
    parameter int NBUFS = 8,
    parameter int SELW  = 3,
    parameter int PW    = 5
) (
    input  logic          sclk,
    input  logic          rst,
    pattern_bank_if.slave bus
);
    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [NBUFS-1:0][DEPTH-1:0][WIDTH-1:0] mem;

    logic [WIDTH-1:0] sh, rb, word_in;
    logic [BW-1:0]    bitcnt;
    logic [PW-1:0]    wp, wp_next;
    logic             wrap;
    logic [SELW-1:0]  sel_q;
    logic             sel_ok, saddr_ok, play_ok;

    state_t           state_q, state_d;
    logic [SELW-1:0]  psel;
    logic [PW-1:0]    rp;

    assign bus.bufs = mem;
    assign bus.sout = rb[WIDTH-1];
    assign bus.busy = (state_q == RUN);

    assign word_in  = {sh[WIDTH-2:0], bus.sin};
    assign wp_next  = (wp == LAST) ? '0 : wp + 1'b1;
    assign sel_ok   = 32'(sel_q) < NBUFS;
    assign saddr_ok = 32'(bus.saddr) < NBUFS;
    assign play_ok  = 32'(bus.play_sel) < NBUFS;

    // Serial load; rb preloads the old word so it shifts out while its replacement shifts in
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            mem     <= '0;
            sh      <= '0;
            rb      <= '0;
            bitcnt  <= '0;
            wp      <= '0;
            wrap    <= 1'b0;
            sel_q   <= '0;
            bus.ovf <= 1'b0;
        end else begin
            if (bus.ovf_clr) bus.ovf <= 1'b0;
            if (!bus.ssel) begin
                bitcnt <= '0;
                wp     <= '0;
                wrap   <= 1'b0;
                sel_q  <= bus.saddr;
                rb     <= saddr_ok ? mem[bus.saddr][0] : '0;
            end else begin
                sh     <= word_in;
                bitcnt <= bitcnt + 1'b1;
                if (bitcnt == BW'(WIDTH - 1)) begin
                    bitcnt <= '0;
                    if (sel_ok) mem[sel_q][wp] <= word_in;
                    rb <= sel_ok ? mem[sel_q][wp_next] : '0;
                    wp <= wp_next;
                    if (wp == LAST) wrap <= 1'b1;
                    // set wins over a same-edge ovf_clr
                    if (wrap) bus.ovf <= 1'b1;
                end else begin
                    rb <= rb << 1;
                end
            end
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.play_go && play_ok) state_d = RUN;
            RUN: begin
                if (bus.play_stop)                  state_d = IDLE;
                else if (rp == LAST && !bus.play_loop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Playback datapath; pat_byte holds its last value on stop
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            psel          <= '0;
            rp            <= '0;
            bus.pat_byte  <= '0;
            bus.pat_valid <= 1'b0;
            bus.pat_last  <= 1'b0;
        end else if (state_q == IDLE) begin
            bus.pat_valid <= 1'b0;
            bus.pat_last  <= 1'b0;
            if (bus.play_go && play_ok) begin
                psel <= bus.play_sel;
                rp   <= '0;
            end
        end else if (bus.play_stop) begin
            bus.pat_valid <= 1'b0;
            bus.pat_last  <= 1'b0;
        end else begin
            bus.pat_byte  <= mem[psel][rp];
            bus.pat_valid <= 1'b1;
            bus.pat_last  <= (rp == LAST);
            rp            <= (rp == LAST) ? '0 : rp + 1'b1;
        end
    end
endmodule
